// File: rtl/cmd_frame_engine_if.sv
// FT245 bridge FIFO handshake between cmd_frame_engine (master) and the rx/tx FIFOs (slave).
interface cmd_frame_engine_if;
    logic       rx_empty;
    logic       rx_rd;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_full;
    logic       tx_wr;
    logic [7:0] tx_data;

    modport master (
        input  rx_empty, rx_valid, rx_data, tx_full,
        output rx_rd, tx_wr, tx_data
    );

    modport slave (
        output rx_empty, rx_valid, rx_data, tx_full,
        input  rx_rd, tx_wr, tx_data
    );
endinterface

// File: rtl/cmd_frame_engine.sv
// Framed command parser (0xAA .. 0x55) executing register reads/writes and sending responses.
// Optional CMD_CHECKSUM_EN adds an XOR checksum byte before the suffix in both directions.
module cmd_frame_engine #(
    parameter int DATA_BYTES = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    cmd_frame_engine_if.master              fifo,
    output logic [NUM_REGS*8*DATA_BYTES-1:0] reg_q,
    output logic [NUM_REGS-1:0]             reg_wr_stb,
    output logic [15:0]                     err_cnt,
    output logic                            busy
);
    localparam int REG_W = 8 * DATA_BYTES;
    localparam int CW    = $clog2(DATA_BYTES + 1);
`ifdef CMD_CHECKSUM_EN
    localparam int RESP_LEN = DATA_BYTES + 5;
`else
    localparam int RESP_LEN = DATA_BYTES + 4;
`endif
    localparam logic [8:0] NREG9 = 9'(NUM_REGS);

    localparam logic [2:0] S_HUNT   = 3'd0;
    localparam logic [2:0] S_OPC    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
`ifdef CMD_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd4;
`endif
    localparam logic [2:0] S_SUFFIX = 3'd5;
    localparam logic [2:0] S_EXEC   = 3'd6;
    localparam logic [2:0] S_RESP   = 3'd7;

    logic [2:0]       state;
    logic             pend;
    logic [CW-1:0]    cnt;
    logic [3:0]       idx;
    logic [REG_W-1:0] regs [NUM_REGS];

    logic [7:0]       opc;
    logic [7:0]       addr;
    logic [REG_W-1:0] data_buf;
    logic [7:0]       resp_opc;
    logic [7:0]       resp_addr;
    logic [REG_W-1:0] resp_data;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]       csum_acc;
    logic [7:0]       resp_csum;
`endif

    logic             take;
    logic             rd_go;
    logic             addr_ok;
    logic             exec_wr;
    logic             exec_rd;
    logic [7:0]       exec_opc;
    logic [REG_W-1:0] exec_data;
    logic [REG_W-1:0] rd_val;
    logic [7:0]       tx_byte;
    logic [7:0]       b;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef CMD_CHECKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [REG_W-1:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < DATA_BYTES; i++) acc = acc ^ v[i*8 +: 8];
        return acc;
    endfunction
`endif

    assign b       = fifo.rx_data;
    assign take    = pend && fifo.rx_valid;
    // A new read is only launched with none outstanding and never while executing/responding.
    assign rd_go   = !fifo.rx_empty && !pend && (state != S_EXEC) && (state != S_RESP);
    assign addr_ok = ({1'b0, addr} < NREG9);
    assign exec_wr = (opc == 8'h01) && addr_ok;
    assign exec_rd = (opc == 8'h02) && addr_ok;
    assign busy    = (state != S_HUNT);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign reg_q[g*REG_W +: REG_W] = regs[g];
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (addr == 8'(i)) rd_val = regs[i];
        exec_opc  = exec_wr ? 8'h81 : (exec_rd ? 8'h82 : 8'hEE);
        exec_data = exec_wr ? data_buf : (exec_rd ? rd_val : '0);
    end

    always_comb begin
        tx_byte = 8'h00;
        if (idx == 4'd0)                      tx_byte = 8'hAA;
        else if (idx == 4'd1)                 tx_byte = resp_opc;
        else if (idx == 4'd2)                 tx_byte = resp_addr;
        else if (idx == 4'(RESP_LEN - 1))     tx_byte = 8'h55;
`ifdef CMD_CHECKSUM_EN
        else if (idx == 4'(RESP_LEN - 2))     tx_byte = resp_csum;
`endif
        else
            for (int d = 0; d < DATA_BYTES; d++)
                if (idx == 4'(3 + d)) tx_byte = resp_data[d*8 +: 8];
    end

    assign fifo.tx_wr   = (state == S_RESP) && !fifo.tx_full;
    assign fifo.tx_data = (state == S_RESP) ? tx_byte : 8'h00;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= S_HUNT;
            pend       <= 1'b0;
            fifo.rx_rd <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            reg_wr_stb <= '0;
            err_cnt    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            fifo.rx_rd <= rd_go;
            if (take)  pend <= 1'b0;
            if (rd_go) pend <= 1'b1;
            reg_wr_stb <= '0;
            case (state)
                S_HUNT:   if (take && b == 8'hAA) state <= S_OPC;
                S_OPC:    if (take) state <= S_ADDR;
                S_ADDR:   if (take) begin
                    state <= S_DATA;
                    cnt   <= '0;
                end
                S_DATA:   if (take) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DATA_BYTES - 1)) begin
`ifdef CMD_CHECKSUM_EN
                        state <= S_CSUM;
`else
                        state <= S_SUFFIX;
`endif
                    end
                end
`ifdef CMD_CHECKSUM_EN
                S_CSUM:   if (take) begin
                    if (b == csum_acc) state <= S_SUFFIX;
                    else begin
                        err_cnt <= sat_inc(err_cnt);
                        state   <= S_HUNT;
                    end
                end
`endif
                // A wrong suffix byte is consumed here, not re-examined as a prefix.
                S_SUFFIX: if (take) begin
                    if (b == 8'h55) state <= S_EXEC;
                    else begin
                        err_cnt <= sat_inc(err_cnt);
                        state   <= S_HUNT;
                    end
                end
                S_EXEC: begin
                    if (exec_wr)
                        for (int i = 0; i < NUM_REGS; i++)
                            if (addr == 8'(i)) begin
                                regs[i]       <= data_buf;
                                reg_wr_stb[i] <= 1'b1;
                            end
                    idx   <= '0;
                    state <= S_RESP;
                end
                S_RESP:   if (fifo.tx_wr) begin
                    if (idx == 4'(RESP_LEN - 1)) state <= S_HUNT;
                    else idx <= idx + 4'd1;
                end
                default:  state <= S_HUNT;
            endcase
        end
    end

    // Frame and response payload registers carry no reset; control gates their use.
    always_ff @(posedge sys_clk) begin
        if (take) begin
            case (state)
                S_OPC:  opc  <= b;
                S_ADDR: addr <= b;
                S_DATA:
                    for (int i = 0; i < DATA_BYTES; i++)
                        if (cnt == CW'(i)) data_buf[i*8 +: 8] <= b;
                default: ;
            endcase
`ifdef CMD_CHECKSUM_EN
            if (state == S_OPC) csum_acc <= b;
            else if (state == S_ADDR || state == S_DATA) csum_acc <= csum_acc ^ b;
`endif
        end
        if (state == S_EXEC) begin
            resp_opc  <= exec_opc;
            resp_addr <= addr;
            resp_data <= exec_data;
`ifdef CMD_CHECKSUM_EN
            resp_csum <= exec_opc ^ addr ^ xor_bytes(exec_data);
`endif
        end
    end
endmodule

// File: tb/tb_cmd_frame_engine.sv
// Scoreboard bench for cmd_frame_engine: FIFO model on rx, expected tx bytes and strobes queued at stimulus time.
module tb_cmd_frame_engine;
    localparam int DB = 4;
    localparam int NR = 4;
    localparam int RW = 8 * DB;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    cmd_frame_engine_if fifo();
    logic [NR*RW-1:0] reg_q;
    logic [NR-1:0]    reg_wr_stb;
    logic [15:0]      err_cnt;
    logic             busy;

    cmd_frame_engine #(.DATA_BYTES(DB), .NUM_REGS(NR)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .fifo       (fifo),
        .reg_q      (reg_q),
        .reg_wr_stb (reg_wr_stb),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] rx_mem [0:1023];
    int pushed = 0;
    int popped = 0;
    assign fifo.rx_empty = (pushed == popped);

    // rx FIFO with one-cycle read latency
    always @(posedge sys_clk) begin
        fifo.rx_valid <= 1'b0;
        if (fifo.rx_rd) begin
            fifo.rx_data  <= rx_mem[popped[9:0]];
            fifo.rx_valid <= 1'b1;
            popped        <= popped + 1;
        end
    end

    logic [7:0]  txq [$];
    logic [3:0]  stb_q [$];
    int          stb_idx_q [$];
    logic [31:0] stb_val_q [$];
    logic [31:0] regs_m [NR];
    logic [15:0] err_m;
    int tx_seen  = 0;
    int stall_rd = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (fifo.rx_rd) check_eq("rd_nonempty", fifo.rx_empty, 0);
            if (fifo.tx_full) begin
                check_eq("tx_hold", fifo.tx_wr, 0);
                if (fifo.rx_rd) stall_rd++;
            end
            if (reg_wr_stb != '0) begin
                if (stb_q.size() == 0) check_eq("stb_spurious", reg_wr_stb, 0);
                else begin
                    int a;
                    a = stb_idx_q.pop_front();
                    check_eq("stb_mask", reg_wr_stb, stb_q.pop_front());
                    check_eq("stb_reg", reg_q[a*RW +: RW], stb_val_q.pop_front());
                    check_eq("stb_tx_same", {fifo.tx_wr, fifo.tx_data}, {1'b1, 8'hAA});
                end
            end
            if (fifo.tx_wr) begin
                tx_seen++;
                if (txq.size() == 0) check_eq("tx_spurious", fifo.tx_wr, 0);
                else check_eq("tx_byte", fifo.tx_data, txq.pop_front());
            end
        end
    end

    task automatic push_byte(input logic [7:0] v);
        rx_mem[pushed[9:0]] = v;
        pushed++;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] opc, input logic [7:0] addr, input logic [31:0] d,
                            input bit bad_sfx, input bit bad_cs);
        logic [7:0]  cs;
        logic [7:0]  rop;
        logic [31:0] rd;
        bit drop;
        int a;
        cs = opc ^ addr ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
`ifdef CMD_CHECKSUM_EN
        drop = bad_sfx || bad_cs;
`else
        drop = bad_sfx || (bad_cs && 1'b0);
`endif
        a = int'(addr);
        if (drop) begin
            if (err_m != 16'hFFFF) err_m++;
        end else begin
            if (opc == 8'h01 && a < NR) begin
                regs_m[a] = d;
                stb_q.push_back(4'(1 << a));
                stb_idx_q.push_back(a);
                stb_val_q.push_back(d);
                rop = 8'h81;
                rd  = d;
            end else if (opc == 8'h02 && a < NR) begin
                rop = 8'h82;
                rd  = regs_m[a];
            end else begin
                rop = 8'hEE;
                rd  = '0;
            end
            txq.push_back(8'hAA);
            txq.push_back(rop);
            txq.push_back(addr);
            for (int k = 0; k < DB; k++) txq.push_back(rd[k*8 +: 8]);
`ifdef CMD_CHECKSUM_EN
            txq.push_back(rop ^ addr ^ rd[7:0] ^ rd[15:8] ^ rd[23:16] ^ rd[31:24]);
`endif
            txq.push_back(8'h55);
        end
        push_byte(8'hAA);
        push_byte(opc);
        push_byte(addr);
        for (int k = 0; k < DB; k++) push_byte(d[k*8 +: 8]);
`ifdef CMD_CHECKSUM_EN
        push_byte(bad_cs ? ~cs : cs);
`endif
        push_byte(bad_sfx ? 8'h56 : 8'h55);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge sys_clk);
            if (pushed == popped && !busy && !fifo.rx_valid && !fifo.rx_rd &&
                txq.size() == 0 && stb_q.size() == 0) done = 1'b1;
        end
        check_eq(tag, done, 1);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            check_eq($sformatf("%s_reg%0d", tag, i), reg_q[i*RW +: RW], regs_m[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rx_rd"},   fifo.rx_rd, 0);
        check_eq({tag, "_tx_wr"},   fifo.tx_wr, 0);
        check_eq({tag, "_tx_data"}, fifo.tx_data, 0);
        check_eq({tag, "_reg_q"},   reg_q, 0);
        check_eq({tag, "_stb"},     reg_wr_stb, 0);
        check_eq({tag, "_err"},     err_cnt, 0);
        check_eq({tag, "_busy"},    busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int base;
        bit started;
        sys_rst      = 1'b1;
        fifo.tx_full = 1'b0;
        err_m        = '0;
        for (int i = 0; i < NR; i++) regs_m[i] = '0;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("rst");
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        // write then read back
        send_cmd(8'h01, 8'h02, 32'h12345678, 1'b0, 1'b0);
        send_cmd(8'h02, 8'h02, 32'h00000000, 1'b0, 1'b0);
        wait_idle("idle_wr_rd");
        check_regs("wr_rd");

        // garbage, bad suffix, then a good write
        push_byte(8'h13);
        push_byte(8'h37);
        send_cmd(8'h01, 8'h00, 32'h44332211, 1'b1, 1'b0);
        send_cmd(8'h01, 8'h01, 32'hCAFEBABE, 1'b0, 1'b0);
        wait_idle("idle_sfx");
        check_eq("err_sfx", err_cnt, err_m);
        check_regs("sfx");

        // nacks
        send_cmd(8'h01, 8'h05, 32'hDEADBEEF, 1'b0, 1'b0);
        send_cmd(8'h07, 8'h00, 32'h01020304, 1'b0, 1'b0);
        send_cmd(8'h02, 8'h01, 32'h00000000, 1'b0, 1'b0);
        wait_idle("idle_nack");
        check_regs("nack");
        check_eq("err_nack", err_cnt, err_m);

        // tx backpressure with the next frame already queued
        base = tx_seen;
        send_cmd(8'h01, 8'h03, 32'hA5A50F0F, 1'b0, 1'b0);
        send_cmd(8'h02, 8'h03, 32'h00000000, 1'b0, 1'b0);
        started = 1'b0;
        for (int i = 0; i < 500 && !started; i++) begin
            @(negedge sys_clk);
            if (tx_seen > base) started = 1'b1;
        end
        check_eq("stall_start", started, 1);
        @(posedge sys_clk);
        #1;
        fifo.tx_full = 1'b1;
        r0 = stall_rd;
        repeat (20) @(posedge sys_clk);
        #1;
        fifo.tx_full = 1'b0;
        check_eq("stall_no_rd", stall_rd - r0, 0);
        wait_idle("idle_stall");
        check_regs("stall");

`ifdef CMD_CHECKSUM_EN
        send_cmd(8'h01, 8'h00, 32'h11111111, 1'b0, 1'b1);
        send_cmd(8'h02, 8'h00, 32'h00000000, 1'b0, 1'b0);
        wait_idle("idle_csum");
        check_eq("err_csum", err_cnt, err_m);
        check_regs("csum");
`endif

        // asynchronous reset after three data bytes
        push_byte(8'hAA);
        push_byte(8'h01);
        push_byte(8'h01);
        push_byte(8'h9A);
        push_byte(8'hBC);
        push_byte(8'hDE);
        started = 1'b0;
        for (int i = 0; i < 200 && !started; i++) begin
            @(negedge sys_clk);
            if (pushed == popped) started = 1'b1;
        end
        check_eq("pre_rst_drain", started, 1);
        #2 sys_rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        for (int i = 0; i < NR; i++) regs_m[i] = '0;
        err_m = '0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        send_cmd(8'h01, 8'h01, 32'h0BADF00D, 1'b0, 1'b0);
        send_cmd(8'h02, 8'h01, 32'h00000000, 1'b0, 1'b0);
        wait_idle("idle_post_rst");
        check_regs("post_rst");
        check_eq("err_post_rst", err_cnt, err_m);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
